// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction buffer: queues fetched words and realigns them into one instruction per cycle.
// Define FETCH_BUFFER_COMPRESSED_EN to enable 16-bit/straddle realignment; otherwise every word is one instruction.
module fetch_buffer #(
    parameter int BUFFER_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_word_i,
    input  logic [31:0] fetch_address_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_address_o,
    output logic        compressed_o,
    input  logic        instr_ready_i,
    output logic        empty_o,
    output logic        full_o
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
`ifdef FETCH_BUFFER_COMPRESSED_EN
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);
`endif

    logic [31:0]      word_q  [BUFFER_DEPTH];
    logic [31:0]      word_d  [BUFFER_DEPTH];
    logic [29:0]      waddr_q [BUFFER_DEPTH];
    logic [29:0]      waddr_d [BUFFER_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             offset_q, offset_d;
    logic             redirect_pending_q, redirect_pending_d;
    logic             instr_valid_q, instr_valid_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      instr_address_q, instr_address_d;
    logic             compressed_q, compressed_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;

    logic             push_s, consume_s, pop_s;
    logic [31:0]      head_word_s;
    logic [31:0]      nxt_h_s;
    logic [31:0]      nxt_addr_s;
`ifdef FETCH_BUFFER_COMPRESSED_EN
    logic [31:0]      nxt_n_s;
    logic             unused_addr_s;
    assign unused_addr_s = fetch_address_i[0];
`else
    logic             unused_addr_s;
    assign unused_addr_s = ^{fetch_address_i[1:0], offset_q};
`endif

    assign fetch_ready_o   = !full_q;
    assign full_o          = full_q;
    assign empty_o         = empty_q;
    assign instr_valid_o   = instr_valid_q;
    assign instr_o         = instr_q;
    assign instr_address_o = instr_address_q;
    assign compressed_o    = compressed_q;

    // Queue state update: flush wins, otherwise consume decides pop/offset and push appends at tail.
    always_comb begin
        word_d             = word_q;
        waddr_d            = waddr_q;
        head_d             = head_q;
        tail_d             = tail_q;
        count_d            = count_q;
        offset_d           = offset_q;
        redirect_pending_d = redirect_pending_q;
        push_s             = fetch_valid_i && !full_q && !flush_i;
        consume_s          = instr_valid_q && instr_ready_i && !flush_i;
        pop_s              = 1'b0;
        head_word_s        = word_q[head_q];
        if (flush_i) begin
            head_d             = '0;
            tail_d             = '0;
            count_d            = '0;
            offset_d           = 1'b0;
            redirect_pending_d = 1'b1;
        end else begin
            if (consume_s) begin
`ifdef FETCH_BUFFER_COMPRESSED_EN
                if (!offset_q) begin
                    if (head_word_s[1:0] != 2'b11) begin
                        offset_d = 1'b1;
                    end else begin
                        pop_s = 1'b1;
                    end
                end else begin
                    pop_s = 1'b1;
                    // A straddle leaves the next instruction starting at the upper half of the new head.
                    if (head_word_s[17:16] != 2'b11) begin
                        offset_d = 1'b0;
                    end else begin
                        offset_d = 1'b1;
                    end
                end
`else
                pop_s = 1'b1;
`endif
            end else begin
                pop_s = 1'b0;
            end
            if (push_s) begin
                word_d[tail_q]  = fetch_word_i;
                waddr_d[tail_q] = fetch_address_i[31:2];
                tail_d          = tail_q + PTR_ONE;
                if (redirect_pending_q) begin
`ifdef FETCH_BUFFER_COMPRESSED_EN
                    offset_d = fetch_address_i[1];
`else
                    offset_d = 1'b0;
`endif
                    redirect_pending_d = 1'b0;
                end else begin
                    redirect_pending_d = 1'b0;
                end
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // Next-cycle instruction view, computed from next state so the outputs can be registered.
    always_comb begin
        nxt_h_s         = word_d[head_d];
        nxt_addr_s      = {waddr_d[head_d], 2'b00};
        instr_valid_d   = 1'b0;
        instr_d         = 32'h0000_0000;
        instr_address_d = 32'h0000_0000;
        compressed_d    = 1'b0;
        empty_d         = (count_d == '0);
        full_d          = (count_d == DEPTH_C);
`ifdef FETCH_BUFFER_COMPRESSED_EN
        nxt_n_s         = word_d[head_d + PTR_ONE];
`endif
        if (count_d != '0) begin
`ifdef FETCH_BUFFER_COMPRESSED_EN
            if (!offset_d) begin
                instr_valid_d   = 1'b1;
                instr_address_d = nxt_addr_s;
                if (nxt_h_s[1:0] != 2'b11) begin
                    instr_d      = {16'h0000, nxt_h_s[15:0]};
                    compressed_d = 1'b1;
                end else begin
                    instr_d      = nxt_h_s;
                    compressed_d = 1'b0;
                end
            end else if (nxt_h_s[17:16] != 2'b11) begin
                instr_valid_d   = 1'b1;
                instr_d         = {16'h0000, nxt_h_s[31:16]};
                instr_address_d = nxt_addr_s + 32'd2;
                compressed_d    = 1'b1;
            end else if (count_d >= TWO_C) begin
                instr_valid_d   = 1'b1;
                instr_d         = {nxt_n_s[15:0], nxt_h_s[31:16]};
                instr_address_d = nxt_addr_s + 32'd2;
                compressed_d    = 1'b0;
            end else begin
                instr_valid_d = 1'b0;
            end
`else
            instr_valid_d   = 1'b1;
            instr_d         = nxt_h_s;
            instr_address_d = nxt_addr_s;
`endif
        end else begin
            instr_valid_d = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            offset_q           <= 1'b0;
            redirect_pending_q <= 1'b1;
            instr_valid_q      <= 1'b0;
            instr_q            <= 32'h0000_0000;
            instr_address_q    <= 32'h0000_0000;
            compressed_q       <= 1'b0;
            empty_q            <= 1'b1;
            full_q             <= 1'b0;
        end else begin
            head_q             <= head_d;
            tail_q             <= tail_d;
            count_q            <= count_d;
            offset_q           <= offset_d;
            redirect_pending_q <= redirect_pending_d;
            instr_valid_q      <= instr_valid_d;
            instr_q            <= instr_d;
            instr_address_q    <= instr_address_d;
            compressed_q       <= compressed_d;
            empty_q            <= empty_d;
            full_q             <= full_d;
        end
    end

    // Entry storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk_i) begin
        word_q  <= word_d;
        waddr_q <= waddr_d;
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer; expectations follow the FETCH_BUFFER_COMPRESSED_EN build setting.
module tb_fetch_buffer;

    logic        clk;
    logic        rst_i;
    logic        flush_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_word_i;
    logic [31:0] fetch_address_i;
    logic        fetch_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_address_o;
    logic        compressed_o;
    logic        instr_ready_i;
    logic        empty_o;
    logic        full_o;

    int tests_run;
    int tests_failed;

    fetch_buffer #(.BUFFER_DEPTH(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_word_i    (fetch_word_i),
        .fetch_address_i (fetch_address_i),
        .fetch_ready_o   (fetch_ready_o),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_address_o (instr_address_o),
        .compressed_o    (compressed_o),
        .instr_ready_i   (instr_ready_i),
        .empty_o         (empty_o),
        .full_o          (full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; flush_i = 1'b0; fetch_valid_i = 1'b0; fetch_word_i = 32'h0;
        fetch_address_i = 32'h0; instr_ready_i = 1'b0;
        tick; tick;
        rst_i = 1'b0;
        tests_run++;
        if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", {instr_valid_o, instr_o, instr_address_o, compressed_o});
        end
        tests_run++;
        if ({empty_o, full_o, fetch_ready_o} !== 3'b101) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 101", {empty_o, full_o, fetch_ready_o});
        end
    endtask

    task automatic test_single_word;
        fetch_valid_i = 1'b1; fetch_word_i = 32'h0050_0093; fetch_address_i = 32'h0000_0100;
        instr_ready_i = 1'b0;
        tick;
        fetch_valid_i = 1'b0;
        tests_run++;
        if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b1, 32'h0050_0093, 32'h0000_0100, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_word: got %h expected %h", {instr_valid_o, instr_o, instr_address_o, compressed_o},
                     {1'b1, 32'h0050_0093, 32'h0000_0100, 1'b0});
        end
        instr_ready_i = 1'b1;
        tick;
        tests_run++;
        if ({empty_o, instr_valid_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_word_drain: got empty,valid=%b expected 10", {empty_o, instr_valid_o});
        end
        instr_ready_i = 1'b0;
    endtask

`ifdef FETCH_BUFFER_COMPRESSED_EN
    task automatic test_two_compressed;
        logic [65:0] exp_v [3];
        exp_v[0] = {1'b1, 32'h0000_4501, 32'h0000_0200, 1'b1};
        exp_v[1] = {1'b1, 32'h0000_0001, 32'h0000_0202, 1'b1};
        exp_v[2] = {1'b0, 32'h0, 32'h0, 1'b0};
        fetch_valid_i = 1'b1; fetch_word_i = 32'h0001_4501; fetch_address_i = 32'h0000_0200;
        instr_ready_i = 1'b1;
        tick;
        fetch_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== exp_v[i]) begin
                tests_failed++;
                $display("FAIL two_compressed[%0d]: got %h expected %h", i,
                         {instr_valid_o, instr_o, instr_address_o, compressed_o}, exp_v[i]);
            end
            tick;
        end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_straddle;
        fetch_valid_i = 1'b1; fetch_word_i = 32'h0093_4505; fetch_address_i = 32'h0000_0300;
        instr_ready_i = 1'b1;
        tick;
        fetch_valid_i = 1'b0;
        tests_run++;
        if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b1, 32'h0000_4505, 32'h0000_0300, 1'b1}) begin
            tests_failed++;
            $display("FAIL straddle_first: got %h", {instr_valid_o, instr_o, instr_address_o, compressed_o});
        end
        tick;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== 66'h0) begin
                tests_failed++;
                $display("FAIL straddle_wait[%0d]: got %h expected 0", i,
                         {instr_valid_o, instr_o, instr_address_o, compressed_o});
            end
            if (i == 0) tick;
        end
        fetch_valid_i = 1'b1; fetch_word_i = 32'h4501_0050; fetch_address_i = 32'h0000_0304;
        tick;
        fetch_valid_i = 1'b0;
        tests_run++;
        if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b1, 32'h0050_0093, 32'h0000_0302, 1'b0}) begin
            tests_failed++;
            $display("FAIL straddle_join: got %h", {instr_valid_o, instr_o, instr_address_o, compressed_o});
        end
        tick;
        tests_run++;
        if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b1, 32'h0000_4501, 32'h0000_0306, 1'b1}) begin
            tests_failed++;
            $display("FAIL straddle_tail: got %h", {instr_valid_o, instr_o, instr_address_o, compressed_o});
        end
        tick;
        tests_run++;
        if ({instr_valid_o, empty_o} !== 2'b01) begin
            tests_failed++;
            $display("FAIL straddle_empty: got valid,empty=%b expected 01", {instr_valid_o, empty_o});
        end
        instr_ready_i = 1'b0;
    endtask
`else
    task automatic test_macro_off;
        fetch_valid_i = 1'b1; fetch_word_i = 32'h0001_4501; fetch_address_i = 32'h0000_0200;
        instr_ready_i = 1'b1;
        tick;
        fetch_valid_i = 1'b0;
        tests_run++;
        if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b1, 32'h0001_4501, 32'h0000_0200, 1'b0}) begin
            tests_failed++;
            $display("FAIL macro_off_word: got %h", {instr_valid_o, instr_o, instr_address_o, compressed_o});
        end
        tick;
        tests_run++;
        if ({instr_valid_o, empty_o} !== 2'b01) begin
            tests_failed++;
            $display("FAIL macro_off_empty: got valid,empty=%b expected 01", {instr_valid_o, empty_o});
        end
        instr_ready_i = 1'b0;
    endtask
`endif

    task automatic test_full_backpressure;
        logic [31:0] w [8];
        for (int i = 0; i < 8; i++) w[i] = 32'hA000_0003 | (32'(i) << 8);
        instr_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fetch_valid_i = 1'b1; fetch_word_i = w[i]; fetch_address_i = 32'h0000_1000 + 32'(i * 4);
            tick;
        end
        fetch_word_i = 32'hDEAD_BEEF; fetch_address_i = 32'h0000_2000;
        tests_run++;
        if ({full_o, fetch_ready_o, empty_o} !== 3'b100) begin
            tests_failed++;
            $display("FAIL full_flags: got full,ready,empty=%b expected 100", {full_o, fetch_ready_o, empty_o});
        end
        tick;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b1, w[i], 32'h0000_1000 + 32'(i * 4), 1'b0}) begin
                tests_failed++;
                $display("FAIL drain[%0d]: got %h expected %h", i, {instr_valid_o, instr_o, instr_address_o, compressed_o},
                         {1'b1, w[i], 32'h0000_1000 + 32'(i * 4), 1'b0});
            end
            tick;
            fetch_valid_i = 1'b0;
        end
        tests_run++;
        if ({instr_valid_o, empty_o, full_o} !== 3'b010) begin
            tests_failed++;
            $display("FAIL drain_end: got valid,empty,full=%b expected 010", {instr_valid_o, empty_o, full_o});
        end
        instr_ready_i = 1'b0;
    endtask

    task automatic test_flush;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_valid_i = 1'b1; fetch_word_i = 32'h1234_0003 + 32'(i * 4); fetch_address_i = 32'h0000_3000 + 32'(i * 4);
            tick;
        end
        flush_i = 1'b1; fetch_word_i = 32'hCAFE_0013; fetch_address_i = 32'h0000_3100;
        tick;
        flush_i = 1'b0; fetch_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if ({empty_o, instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b1, 66'h0}) begin
                tests_failed++;
                $display("FAIL flush_empty[%0d]: got %h expected %h", i,
                         {empty_o, instr_valid_o, instr_o, instr_address_o, compressed_o}, {1'b1, 66'h0});
            end
            tick;
        end
        fetch_valid_i = 1'b1; fetch_word_i = 32'h4505_0000; fetch_address_i = 32'h0000_0402;
        instr_ready_i = 1'b1;
        tick;
        fetch_valid_i = 1'b0;
        tests_run++;
`ifdef FETCH_BUFFER_COMPRESSED_EN
        if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b1, 32'h0000_4505, 32'h0000_0402, 1'b1}) begin
`else
        if ({instr_valid_o, instr_o, instr_address_o, compressed_o} !== {1'b1, 32'h4505_0000, 32'h0000_0400, 1'b0}) begin
`endif
            tests_failed++;
            $display("FAIL flush_refetch: got %h", {instr_valid_o, instr_o, instr_address_o, compressed_o});
        end
        tick;
        tests_run++;
        if ({instr_valid_o, empty_o} !== 2'b01) begin
            tests_failed++;
            $display("FAIL flush_refetch_empty: got valid,empty=%b expected 01", {instr_valid_o, empty_o});
        end
        instr_ready_i = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset;
        test_single_word;
`ifdef FETCH_BUFFER_COMPRESSED_EN
        test_two_compressed;
        test_straddle;
`else
        test_macro_off;
`endif
        test_full_backpressure;
        test_flush;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
